instr_mem_cargable: RTL and testbench

//  Parametrised instruction memory for the pipelined MIPS IF stage with an integrated byte-serial

---
 rtl/instr_mem_cargable.sv | 104 ++++++++++
 tb/tb_instr_mem_cargable.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instr_mem_cargable.sv
// Instruction memory for the IF stage with a byte-serial program loader.
// Bytes are packed MSB-first into words and written at auto-incrementing addresses.
module instr_mem_cargable #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD  = 32'h00000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_load_start,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic                  o_valid,
  output logic                  o_loading,
  output logic                  o_load_done,
  output logic                  o_overflow,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [CNT_W-1:0]        byte_cnt;
  logic [DATA_WIDTH-1:0]   asm_q;
  logic [DATA_WIDTH-1:0]   asm_next;
  logic                    last_byte;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   rd_idx;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign asm_next  = (asm_q << 8) | DATA_WIDTH'(i_byte);
  assign last_byte = (byte_cnt == CNT_W'(BYTES - 1));
  // A byte coinciding with a (re)start or reset is dropped, so it never writes.
  assign wr_en     = !i_reset && !i_load_start && (state == LOAD) && i_byte_valid && last_byte;
  assign rd_idx    = i_pc[ADDR_WIDTH+1:2];

  // Loader FSM
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      o_word_count <= '0;
      o_overflow   <= 1'b0;
    end else if (i_load_start) begin
      state        <= LOAD;
      wr_ptr       <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      o_word_count <= '0;
      o_overflow   <= 1'b0;
    end else if (state == LOAD && i_byte_valid) begin
      asm_q <= asm_next;
      if (last_byte) begin
        byte_cnt     <= '0;
        wr_ptr       <= wr_ptr + 1'b1;
        o_word_count <= o_word_count + 1'b1;
        if (asm_next == HALT_WORD) begin
          state <= DONE;
        end else if (wr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
          state      <= DONE;
          o_overflow <= 1'b1;
        end
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  // Storage is never cleared; reset only affects control state.
  always_ff @(posedge i_clock) begin
    if (wr_en) mem[wr_ptr] <= asm_next;
  end

  // Fetch port: flush > stall > fetch, forced NOP while loading.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_instruccion <= NOP_WORD;
      o_valid       <= 1'b0;
    end else if (state == LOAD || i_flush) begin
      o_instruccion <= NOP_WORD;
      o_valid       <= 1'b0;
    end else if (i_enable) begin
      o_instruccion <= mem[rd_idx];
      o_valid       <= 1'b1;
    end
  end

  assign o_loading   = (state == LOAD);
  assign o_load_done = (state == DONE);

endmodule

// File: tb/tb_instr_mem_cargable.sv
// Directed bench for instr_mem_cargable: a default instance and a 4-word instance
// share stimulus; the small one exercises the memory-full stop.
module tb_instr_mem_cargable;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        en, flush, start, bvld;
  logic [7:0]  bdat;

  logic [31:0] instr, instr_s;
  logic        vld, vld_s, loading, loading_s, done, done_s, ovf, ovf_s;
  logic [8:0]  wcnt;
  logic [2:0]  wcnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_mem_cargable dut (
    .i_clock(clk), .i_reset(rst), .i_pc(pc), .i_enable(en), .i_flush(flush),
    .i_load_start(start), .i_byte_valid(bvld), .i_byte(bdat),
    .o_instruccion(instr), .o_valid(vld), .o_loading(loading),
    .o_load_done(done), .o_overflow(ovf), .o_word_count(wcnt)
  );

  instr_mem_cargable #(.ADDR_WIDTH(2)) dut_s (
    .i_clock(clk), .i_reset(rst), .i_pc(pc), .i_enable(en), .i_flush(flush),
    .i_load_start(start), .i_byte_valid(bvld), .i_byte(bdat),
    .o_instruccion(instr_s), .o_valid(vld_s), .o_loading(loading_s),
    .o_load_done(done_s), .o_overflow(ovf_s), .o_word_count(wcnt_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bvld = 1'b1; bdat = b; tick(); bvld = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic fetch(input logic [31:0] a);
    pc = a; en = 1'b1; tick(); en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = '0; en = 1'b0; flush = 1'b0; start = 1'b0; bvld = 1'b0; bdat = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_instr", instr, 32'h0);
    check("rst_valid", vld, 0);
    check("rst_loading", loading, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_wcnt", wcnt, 0);

    // Basic load: one instruction plus HALT
    pulse_start();
    check("ld_loading", loading, 1);
    check("ld_wcnt0", wcnt, 0);
    send_word(32'h20080005);
    check("ld_wcnt1", wcnt, 1);
    check("ld_valid_in_load", vld, 0);
    send_word(32'hFFFFFFFF);
    check("ld_done", done, 1);
    check("ld_loading_off", loading, 0);
    check("ld_wcnt2", wcnt, 2);
    check("ld_ovf", ovf, 0);
    fetch(32'd0);
    check("fetch0_instr", instr, 32'h20080005);
    check("fetch0_valid", vld, 1);

    // Stall holds the previous word
    pc = 32'd4; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instr", instr, 32'h20080005);
      check("stall_valid", vld, 1);
    end
    fetch(32'd4);
    check("fetch1_halt", instr, 32'hFFFFFFFF);

    // Low bits ignored, high bits wrap
    fetch(32'h0000_0403);
    check("fetch_wrap0", instr, 32'h20080005);
    fetch(32'h0000_0406);
    check("fetch_wrap1", instr, 32'hFFFFFFFF);

    // Flush beats enable
    flush = 1'b1; fetch(32'd0); flush = 1'b0;
    check("flush_instr", instr, 32'h0);
    check("flush_valid", vld, 0);

    // Overflow on the 4-word instance
    pulse_start();
    for (int k = 0; k < 4; k++) send_word(32'h10 + k);
    check("ovf_done", done_s, 1);
    check("ovf_flag", ovf_s, 1);
    check("ovf_wcnt", wcnt_s, 4);
    check("ovf_big_loading", loading, 1);
    send_word(32'h14);
    check("ovf_5th_ignored", wcnt_s, 4);
    check("ovf_big_wcnt5", wcnt, 5);
    fetch(32'd12);
    check("ovf_mem3", instr_s, 32'h13);
    check("ovf_mem3_valid", vld_s, 1);
    check("ovf_big_nop", vld, 0);
    fetch(32'd16);
    check("ovf_wrap_mem0", instr_s, 32'h10);

    // Reset mid-load drops the partial word only
    pulse_start();
    send_word(32'hAABBCCDD);
    send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_loading", loading, 0);
    check("mrst_wcnt", wcnt, 0);
    pulse_start();
    send_word(32'hFFFFFFFF);
    check("mrst_wcnt1", wcnt, 1);
    check("mrst_done", done, 1);
    check("mrst_ovf", ovf, 0);
    fetch(32'd0);
    check("mrst_mem0", instr, 32'hFFFFFFFF);
    fetch(32'd4);
    check("mrst_mem1_kept", instr, 32'h11);

    // Restart inside LOAD discards the partial word
    pulse_start();
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    check("rs_wcnt1", wcnt, 1);
    check("rs_valid", vld, 0);
    pulse_start();
    check("rs_wcnt0", wcnt, 0);
    check("rs_loading", loading, 1);
    check("rs_valid2", vld, 0);
    send_word(32'h05060708);
    send_word(32'hFFFFFFFF);
    check("rs_wcnt2", wcnt, 2);
    check("rs_done", done, 1);
    fetch(32'd0);
    check("rs_mem0", instr, 32'h05060708);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
